// File: rtl/vga_text_renderer_if.sv
// Bundle of timing-generator, memory and DAC signals around the text renderer.
// Latency: none (wiring only).
// Backpressure: none; every signal is sampled or driven every pixel clock.
interface vga_text_renderer_if;
  // Timing generator side
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  // Character RAM and font ROM (1-cycle synchronous reads)
  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  // Cursor control
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  // DAC / pins
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;

  // Environment: timing generator, memories, cursor registers, display sink
  modport master (
    output pixel_x, pixel_y, video_on, hsync, vsync,
    output char_data, font_data,
    output cursor_en, cursor_col, cursor_row,
    input  char_addr, font_addr,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs
  );

  // Renderer
  modport slave (
    input  pixel_x, pixel_y, video_on, hsync, vsync,
    input  char_data, font_data,
    input  cursor_en, cursor_col, cursor_row,
    output char_addr, font_addr,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs
  );
endinterface

// File: rtl/vga_text_renderer.sv
// 80x30 text-mode pixel pipeline: char RAM -> font ROM -> RGB with inverse and blinking cursor.
// Latency: 3 pixel clocks from timing inputs to vga_* (RGB and syncs aligned).
// Backpressure: none; one pixel accepted every clock, memories assumed 1-cycle, never stall.
module vga_text_renderer #(
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter int          BLINK_BIT = 4
) (
  input  logic                 clk_pixel,
  input  logic                 rst,
  vga_text_renderer_if.slave   vif
);

  // Stage 0 decode
  logic [6:0]  cell_col;
  logic [4:0]  cell_row;
  logic        in_area;
  logic [11:0] cell_addr;
  logic        cursor_hit_d;

  // Stage 1 registers (P1)
  logic [2:0]  p1_gcol_q;
  logic [3:0]  p1_grow_q;
  logic        p1_von_q;
  logic        p1_hs_q;
  logic        p1_vs_q;
  logic        p1_cur_q;

  // Stage 2 registers (P2)
  logic [2:0]  p2_gcol_q;
  logic        p2_von_q;
  logic        p2_hs_q;
  logic        p2_vs_q;
  logic        p2_cur_q;
  logic        p2_inv_q;

  // Output registers
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q;
  logic        vs_q;

  // Blink state
  logic        vs_edge_q;
  logic [4:0]  frame_cnt_q, frame_cnt_d;
  logic        cursor_visible;
  logic        glyph_bit;
  logic        pixel_on;

  // Stage 0: cell coordinates, RAM address (row*80 via shifts), cursor match
  always_comb begin
    cell_col     = vif.pixel_x[9:3];
    cell_row     = vif.pixel_y[8:4];
    in_area      = (vif.pixel_x < 10'd640) && (vif.pixel_y < 10'd480);
    cell_addr    = {1'b0, cell_row, 6'b0} + {3'b0, cell_row, 4'b0} + {5'b0, cell_col};
    cursor_hit_d = vif.cursor_en && (cell_col == vif.cursor_col) &&
                   (cell_row == vif.cursor_row) && (vif.pixel_y[3:0] >= 4'd14);
  end

  // Blanking forces address 0 so the RAM never sees out-of-range addresses
  assign vif.char_addr = in_area ? cell_addr : 12'd0;

  // Stage 1: char_data has arrived; glyph row selects the font line
  assign vif.font_addr = {vif.char_data[6:0], p1_grow_q};

  // P1: capture pixel position within glyph, video flag, syncs and cursor match
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      p1_gcol_q <= 3'd0;
      p1_grow_q <= 4'd0;
      p1_von_q  <= 1'b0;
      p1_hs_q   <= 1'b1;
      p1_vs_q   <= 1'b1;
      p1_cur_q  <= 1'b0;
    end else begin
      p1_gcol_q <= vif.pixel_x[2:0];
      p1_grow_q <= vif.pixel_y[3:0];
      p1_von_q  <= vif.video_on;
      p1_hs_q   <= vif.hsync;
      p1_vs_q   <= vif.vsync;
      p1_cur_q  <= cursor_hit_d;
    end
  end

  // P2: carry P1 forward and latch the inverse attribute from char_data
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      p2_gcol_q <= 3'd0;
      p2_von_q  <= 1'b0;
      p2_hs_q   <= 1'b1;
      p2_vs_q   <= 1'b1;
      p2_cur_q  <= 1'b0;
      p2_inv_q  <= 1'b0;
    end else begin
      p2_gcol_q <= p1_gcol_q;
      p2_von_q  <= p1_von_q;
      p2_hs_q   <= p1_hs_q;
      p2_vs_q   <= p1_vs_q;
      p2_cur_q  <= p1_cur_q;
      p2_inv_q  <= vif.char_data[7];
    end
  end

  // Stage 2: pick glyph bit (MSB leftmost), apply inverse, cursor and blanking
  always_comb begin
    cursor_visible = ~frame_cnt_q[BLINK_BIT];
    glyph_bit      = vif.font_data[3'd7 - p2_gcol_q];
    pixel_on       = (glyph_bit ^ p2_inv_q) | (p2_cur_q & cursor_visible);
    rgb_d          = BG_COLOR;
    if (pixel_on) begin
      rgb_d = FG_COLOR;
    end
    if (!p2_von_q) begin
      rgb_d = 12'h000;
    end
  end

  // Output register: colour and syncs leave together
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      rgb_q <= 12'h000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= p2_hs_q;
      vs_q  <= p2_vs_q;
    end
  end

  assign vif.vga_r  = rgb_q[11:8];
  assign vif.vga_g  = rgb_q[7:4];
  assign vif.vga_b  = rgb_q[3:0];
  assign vif.vga_hs = hs_q;
  assign vif.vga_vs = vs_q;

  // Frame counter advances on each vsync falling edge (wraps naturally at 5 bits)
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vs_edge_q && !vif.vsync) begin
      frame_cnt_d = frame_cnt_q + 5'd1;
    end
  end

  // Blink state; an edge seen while in reset is discarded
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      vs_edge_q   <= 1'b1;
      frame_cnt_q <= 5'd0;
    end else begin
      vs_edge_q   <= vif.vsync;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Scoreboard bench for the text renderer: expected pixels queued at drive time, compared 3 clocks later.
// Latency: model assumes 3-cycle pipeline and 1-cycle RAM/ROM.
// Backpressure: none; one pixel driven per clock.
module tb_vga_text_renderer;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic clk;
  logic rst;
  vga_text_renderer_if vif();

  vga_text_renderer dut (
    .clk_pixel (clk),
    .rst       (rst),
    .vif       (vif)
  );

  logic [7:0] cram [0:4095];
  logic [7:0] from [0:2047];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  logic [4:0] fc_m = 5'd0;
  logic       prev_vs_m = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory models
  always @(posedge clk) begin
    vif.char_data <= cram[vif.char_addr];
    vif.font_data <= from[vif.font_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one pixel, check addresses, queue expected output, compare output due this cycle
  task automatic step(input int x, input int y, input bit von, input bit hs, input bit vs);
    int         addr;
    logic [7:0] code;
    logic [7:0] fb;
    logic [10:0] fidx;
    logic       bitv;
    logic       hit;
    logic       on;
    logic [11:0] rgb;
    bit         was_rst;
    exp_t       e;
    exp_t       got;

    vif.pixel_x  = 10'(x);
    vif.pixel_y  = 10'(y);
    vif.video_on = von;
    vif.hsync    = hs;
    vif.vsync    = vs;
    was_rst      = rst;

    addr = (x < 640 && y < 480) ? ((y / 16) * 80 + x / 8) : 0;
    #1;
    chk("char_addr", 32'(vif.char_addr), 32'(addr));

    if (rst) begin
      fc_m      = 5'd0;
      prev_vs_m = 1'b1;
    end else begin
      if (prev_vs_m && !vs) fc_m = fc_m + 5'd1;
      prev_vs_m = vs;
    end

    code = cram[addr];
    fidx = {code[6:0], 4'(y % 16)};
    fb   = from[fidx];
    bitv = fb[7 - (x % 8)];
    hit  = vif.cursor_en && ((x / 8) == int'(vif.cursor_col)) &&
           (((y / 16) % 32) == int'(vif.cursor_row)) && ((y % 16) >= 14);
    on   = (bitv ^ code[7]) | (hit & ~fc_m[4]);
    rgb  = !von ? 12'h000 : (on ? 12'hFFF : 12'h000);

    if (rst) e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
    else     e = '{rgb: rgb, hs: hs, vs: vs};
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    if (!was_rst) chk("font_addr", 32'(vif.font_addr), 32'(fidx));
    if (exp_q.size() == 3) begin
      e   = exp_q.pop_front();
      got = '{rgb: {vif.vga_r, vif.vga_g, vif.vga_b}, hs: vif.vga_hs, vs: vif.vga_vs};
      chk("rgb", 32'(got.rgb), 32'(e.rgb));
      chk("hs",  32'(got.hs),  32'(e.hs));
      chk("vs",  32'(got.vs),  32'(e.vs));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(700, 500, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) cram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) from[i] = 8'h00;
    cram[162]  = 8'h41;   // row 2, col 2
    from[11'h413] = 8'hFF;
    cram[250]  = 8'hC1;   // row 3, col 10, inverse 'A'
    from[11'h412] = 8'h80;
    cram[2399] = 8'h41;

    vif.cursor_en  = 1'b0;
    vif.cursor_col = 7'd0;
    vif.cursor_row = 5'd0;
    rst = 1'b1;

    // Reset held with active-looking inputs: outputs must stay blank/inactive
    for (int i = 0; i < 5; i++) step(17, 35, 1'b1, 1'b0, i[0]);
    rst = 1'b0;
    idle(3);

    // Mapping: x=17,y=35 -> 162, font {0x41,3}, glyph 0xFF -> white
    step(17, 35, 1'b1, 1'b1, 1'b1);
    step(23, 35, 1'b1, 1'b1, 1'b1);
    // Blanked with lit glyph -> black
    step(17, 35, 1'b0, 1'b1, 1'b1);
    idle(3);

    // Inverse video: bit set -> black, bit clear -> white
    step(80, 50, 1'b1, 1'b1, 1'b1);
    step(81, 50, 1'b1, 1'b1, 1'b1);
    idle(4);
    from[11'h412] = 8'h00;
    step(80, 50, 1'b1, 1'b1, 1'b1);
    idle(3);

    // Last visible line through horizontal blanking and hsync pulse
    for (int x = 600; x < 800; x++)
      step(x, 479, x < 640, !(x >= 656 && x <= 751), 1'b1);
    // New line starts at column 0
    step(0, 16, 1'b1, 1'b1, 1'b1);
    step(7, 16, 1'b1, 1'b1, 1'b1);
    idle(3);

    // Cursor at (5,2): glyph row 13 stays dark, row 14 blinks with frame counter
    vif.cursor_en  = 1'b1;
    vif.cursor_col = 7'd5;
    vif.cursor_row = 5'd2;
    step(42, 45, 1'b1, 1'b1, 1'b1);
    idle(3);
    for (int f = 0; f < 34; f++) begin
      step(42, 46, 1'b1, 1'b1, 1'b1);
      idle(3);
      step(700, 500, 1'b0, 1'b1, 1'b0);
      step(700, 500, 1'b0, 1'b1, 1'b0);
      step(700, 500, 1'b0, 1'b1, 1'b1);
    end
    // Cursor disable takes effect immediately
    vif.cursor_en = 1'b0;
    step(42, 46, 1'b1, 1'b1, 1'b1);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/vga_text_renderer.md
# vga_text_renderer

Pixel-pipeline stage directly downstream of the VGA timing generator: consumes its pixel coordinates, `video_on`, `hsync` and `vsync`, and produces 4:4:4 RGB plus delay-matched sync for the DAC/pins. Implements an 80x30 character text mode with 8x16 glyphs. Glyphs are fetched from an external character RAM and font ROM, both with synchronous reads. Adds per-character inverse video and a blinking underline cursor.

## Interface
Parameters:
- `FG_COLOR`, 12'hFFF: foreground RGB {r,g,b} 4 bits each.
- `BG_COLOR`, 12'h000: background RGB.
- `BLINK_BIT`, 4: frame-counter bit that gates the cursor (cursor shown while that bit is 0).

Ports:
- `clk_pixel` in 1: pixel clock, ~25 MHz. One clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pixel_x` in 10: current column from the timing generator.
- `pixel_y` in 10: current line.
- `video_on` in 1: visible-area flag.
- `hsync` in 1: horizontal sync, active low.
- `vsync` in 1: vertical sync, active low.
- `char_addr` out 12: character RAM address, combinational.
- `char_data` in 8: RAM data, valid 1 cycle after `char_addr`. Bit 7 = inverse, bits 6:0 = code.
- `font_addr` out 11: {code[6:0], glyph_row[3:0]}, combinational.
- `font_data` in 8: glyph row, valid 1 cycle after `font_addr`. Bit 7 = leftmost pixel.
- `cursor_en` in 1: cursor enable.
- `cursor_col` in 7: cursor column, 0..79.
- `cursor_row` in 5: cursor row, 0..29.
- `vga_r`, `vga_g`, `vga_b` out 4 each: pixel colour, registered.
- `vga_hs`, `vga_vs` out 1: sync, delayed 3 cycles, registered.

## Operation
- Cell column = `pixel_x[9:3]`, cell row = `pixel_y[8:4]`.
- `char_addr` = row*80 + col, computed as (row<<6)+(row<<4)+col in 12 bits.
- `char_addr` = 0 when `pixel_x` >= 640 or `pixel_y` >= 480.
- Stage 0 (cycle t):
  - Drive `char_addr`.
  - Register into P1: `pixel_x[2:0]`, `pixel_y[3:0]`, `video_on`, `hsync`, `vsync`.
  - Register cursor_hit = `cursor_en` & col==`cursor_col` & row==`cursor_row` & `pixel_y[3:0]`>=14.
- Stage 1 (t+1):
  - `font_addr` = {`char_data[6:0]`, P1.glyph_row}.
  - Register P1 fields and `char_data[7]` (inverse) into P2.
- Stage 2 (t+2):
  - bit = `font_data`[7 - P2.glyph_col].
  - on = bit XOR inverse.
  - Force on = 1 if cursor_hit & cursor_visible.
  - Colour = on ? `FG_COLOR` : `BG_COLOR`.
  - Force colour = 0 if P2.video_on = 0.
  - Register colour into `vga_r/g/b`; register P2 syncs into `vga_hs/vga_vs`.
- Blink:
  - 5-bit `frame_cnt` increments on each `vsync` falling edge, detected against a registered copy of `vsync`.
  - Wraps 31 -> 0.
  - cursor_visible = ~`frame_cnt[BLINK_BIT]`.
- Reset:
  - `vga_r/g/b` = 0, `vga_hs` = `vga_vs` = 1.
  - All pipeline video_on flags 0, pipeline syncs 1.
  - `frame_cnt` = 0, vsync-edge register = 1.
  - Reset asserted mid-line takes effect next edge. Outputs stay blank/inactive for 3 cycles after release until valid data propagates.

## Timing
- Latency: inputs at edge t appear on `vga_*` after edge t+3. RGB and sync stay mutually aligned.
- Memory contract: exactly 1 cycle read latency for both RAM and ROM, no stalls. Block never back-pressures the timing generator.
- Boundaries:
  - x = 639/y = 479 -> `char_addr` 2399.
  - x = 0 of a new line -> column 0 with no carry from the previous line.
  - Blanking region: addresses 0, output black, syncs pass through delayed.
- A cursor change takes effect for pixels entering stage 0 on or after the change.
- A vsync edge coinciding with reset is ignored.

## Test plan
- Reset held, arbitrary inputs -> `vga_r/g/b` = 0 and `vga_hs` = `vga_vs` = 1. After release with `video_on` = 0: same for 3 cycles.
- Coordinate and address mapping:
  - x = 17, y = 35 -> `char_addr` = 2*80+2 = 162 the same cycle.
  - Model returns `char_data` 0x41 -> `font_addr` = {0x41, 3} = 0x413 next cycle.
  - `font_data` 0xFF -> `vga_r/g/b` = F,F,F at t+3.
- Inverse:
  - `char_data` 0xC1 with `font_data` bit = 1 -> output black.
  - `font_data` 0x00 -> output white at same pixel.
- Blanking and sync: `video_on` = 0 with `font_data` 0xFF -> black. `hsync` pulse at x = 656..751 appears on `vga_hs` at x = 659..754 (3-cycle delay).
- Wrap: x = 639, y = 479 -> `char_addr` 2399. x = 700 -> `char_addr` 0.
- Cursor blink:
  - `cursor_en` = 1, cursor (5,2), y = 46 (glyph row 14), `font_data` 0 -> white for frames 0..15.
  - Black after the 16th vsync falling edge.
  - Visible again after the 32nd.
